// File: rtl/scan_pkg.sv
// Shared constants, FSM state type and the lowest-set-bit helper for the
// channel scan sequencer feeding the 3-to-8 one-hot decoder.
package scan_pkg;

    localparam int IDX_W  = 3;
    localparam int NUM_CH = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Index of the lowest set bit; 0 when the mask is empty.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_CH-1:0] m);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i]) begin
                r = IDX_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_next_index.sv
// Combinational round-robin successor: next set mask bit strictly above cur,
// searching cyclically, with a wrap flag and an empty-mask flag.
module rr_next_index
    import scan_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [IDX_W-1:0]  cur,
    output logic [IDX_W-1:0]  nxt,
    output logic              wrapped,
    output logic              none
);

    logic [IDX_W-1:0] cand;
    logic             found;

    // Offsets 1..NUM_CH; the last offset lands on cur itself, so a lone
    // enabled channel selects itself and reports a wrap.
    always_comb begin
        nxt   = cur;
        cand  = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = IDX_W'(int'(cur) + k);
            if (!found && mask[cand]) begin
                nxt   = cand;
                found = 1'b1;
            end
        end
    end

    assign wrapped = (nxt <= cur);
    assign none    = (mask == '0);

endmodule

// File: rtl/scan_sequencer.sv
// Steps a registered channel index through the enabled mask bits, dwelling
// div_max+1 cycles per channel; all outputs are registered.
module scan_sequencer #(
    parameter int DIV_W  = 16,
    parameter int IDX_W  = 3,
    parameter int NUM_CH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [NUM_CH-1:0] mask,
    input  logic [DIV_W-1:0]  div_max,
    output logic [IDX_W-1:0]  idx,
    output logic              idx_valid,
    output logic              tick,
    output logic              wrap
);

    import scan_pkg::*;

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [IDX_W-1:0] nxt;
    logic             nxt_wrapped;
    logic             mask_none;

    rr_next_index u_next (
        .mask    (mask),
        .cur     (idx),
        .nxt     (nxt),
        .wrapped (nxt_wrapped),
        .none    (mask_none)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            div_cnt   <= '0;
            idx       <= '0;
            idx_valid <= 1'b0;
            tick      <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    div_cnt   <= '0;
                    idx_valid <= 1'b0;
                    tick      <= 1'b0;
                    wrap      <= 1'b0;
                    if (en && !mask_none) begin
                        state     <= RUN;
                        idx       <= lowest_set(mask);
                        idx_valid <= 1'b1;
                        tick      <= 1'b1;
                    end
                end
                RUN: begin
                    // Stopping outranks advancing; idx keeps its last value.
                    if (!en || mask_none) begin
                        state     <= IDLE;
                        div_cnt   <= '0;
                        idx_valid <= 1'b0;
                        tick      <= 1'b0;
                        wrap      <= 1'b0;
                    end else if (div_cnt >= div_max) begin
                        // >= lets a div_max lowered mid-dwell end it at once.
                        div_cnt <= '0;
                        idx     <= nxt;
                        tick    <= 1'b1;
                        wrap    <= nxt_wrapped;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                        tick    <= 1'b0;
                        wrap    <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    div_cnt   <= '0;
                    idx_valid <= 1'b0;
                    tick      <= 1'b0;
                    wrap      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/scan_sequencer.md
Name: scan_sequencer

Overview:
- Upstream stage of the 3-to-8 one-hot decoder.
- Steps a 3-bit channel index through the enabled channels of an 8-bit mask, dwelling a programmable number of cycles on each.
- Typical uses: digit or LED scan, time-multiplexed channel select.
- Outputs are registered, so the decoder's one-hot output is glitch-free.

Parameters:
- DIV_W, 16, width of the dwell counter and the div_max port.
- IDX_W, 3, index width. Fixed at 3 for the 8-channel decoder.
- NUM_CH, 8, channel count. Equals 2**IDX_W.

Ports:
- clk  in  1  single clock for all state.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run enable.
- mask  in  NUM_CH  channel enable bits; bit i set means channel i is visited.
- div_max  in  DIV_W  dwell length minus 1, in cycles.
- idx  out  IDX_W  current channel index, registered; feeds the decoder select.
- idx_valid  out  1  high while idx is driving an active scan.
- tick  out  1  one-cycle pulse on the cycle a new idx is first presented.
- wrap  out  1  one-cycle pulse, coincident with tick, when the sequence wrapped to a lower-or-equal index.

Behaviour:
- Reset (rst sampled high at a clk edge):
  - state=IDLE, div_cnt=0, idx=0, idx_valid=0, tick=0, wrap=0.
  - Applies identically mid-scan; no partial dwell is retained.
- State IDLE:
  - idx_valid=0, tick=0, wrap=0, idx holds its last value, div_cnt=0.
  - Transition when en=1 and mask!=0: go to RUN.
  - On that edge: idx<=lowest set bit of mask, idx_valid<=1, tick<=1, wrap<=0, div_cnt<=0.
- State RUN, per cycle:
  - div_cnt increments.
  - Terminal condition: div_cnt>=div_max. The compare uses >=, so a div_max lowered mid-dwell below div_cnt terminates on the next cycle.
  - On terminal:
    - div_cnt<=0, tick<=1.
    - idx<=next set bit of mask strictly above idx, searching cyclically 7→0.
    - wrap<=1 if that new index <= old idx, else 0.
  - Single enabled channel: idx is unchanged and wrap=1 on every terminal.
  - Non-terminal cycles: tick=0, wrap=0.
- Dwell length: every channel is presented for exactly div_max+1 cycles. div_max=0 advances every cycle, giving tick high continuously.
- Exits from RUN (each takes priority over advance in the same cycle):
  - en=0 → IDLE on the next edge: idx_valid<=0, tick/wrap<=0, idx holds.
  - mask==0 → IDLE on the next edge with the same outputs.
- Mask changes:
  - mask is sampled only at terminal, for next-index selection.
  - Clearing the current channel's bit mid-dwell does not shorten the dwell.
- Latency: en rising (with mask!=0) → idx_valid high 1 cycle later.
- No combinational path from any input to any output.

Decomposition:
- Package scan_pkg holds:
  - IDX_W and NUM_CH constants.
  - State enum {IDLE, RUN}.
  - A function for the lowest set bit.
- Sub-module rr_next_index:
  - Combinational.
  - Inputs: mask[NUM_CH], cur[IDX_W].
  - Outputs: nxt[IDX_W], wrapped, none (mask==0).
  - Implementation: rotating priority search.
- scan_sequencer instantiates rr_next_index once and owns the FSM, the dwell counter and the output registers.

Test Plan:
- Reset/start:
  - Stimulus: rst high 2 cycles, then en=1, mask=8'hFF, div_max=2.
  - Response: idx_valid rises 1 cycle after en.
  - idx sequence is 0,1,…,7,0, each held 3 cycles.
  - tick every 3 cycles; wrap only on the 7→0 step.
- Sparse mask:
  - Stimulus: mask=8'b1010_0100, div_max=0.
  - Response: idx=2,5,7,2,5… changing every cycle.
  - tick constantly 1; wrap=1 on each 7→2 step.
- Single channel:
  - Stimulus: mask=8'h10, div_max=3.
  - Response: idx stays 4.
  - tick and wrap pulse together every 4 cycles.
- Enable drop and restart:
  - Stimulus: deassert en at idx=3, mid-dwell.
  - Response: next cycle idx_valid=0, idx=3, tick=0.
  - Reassert en with mask=8'hFF: idx restarts at 0 with tick=1.
- Mask to zero and dwell shrink:
  - Stimulus: set mask=0 in RUN.
  - Response: IDLE next cycle.
  - Separately: with div_max=10 and div_cnt=6, write div_max=2.
  - Response: advance occurs on the next cycle.
- Reset mid-scan:
  - Stimulus: pulse rst for 1 cycle at idx=6, div_cnt=1.
  - Response: all outputs 0 on the next edge; with en held 1, the scan restarts at the lowest mask bit 1 cycle after rst falls.
